divu_iter: RTL and testbench

//   Multi-cycle unsigned integer divider: the inverse arithmetic path to the adder/CLA datapath.

---
 rtl/divu_iter.sv | 110 +++++++++++
 tb/tb_divu_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_iter.sv
// Iterative restoring unsigned divider, one op in flight; result WIDTH/STEPS_PER_CYCLE cycles after accept.
// in_ready only in IDLE; the result holds in DONE until out_ready, then one IDLE cycle before the next accept.
module divu_iter #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int ITERS = WIDTH / STEPS_PER_CYCLE;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_part;
    logic [WIDTH:0]   w_trial;
    logic             w_accept;
    logic             w_last;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CW'(ITERS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Trial subtraction is one bit wider than the operands: the shifted
    // partial remainder can reach 2*divisor-1, which overflows WIDTH bits.
    always_comb begin
        w_q     = r_q;
        w_part  = r_part;
        w_trial = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            w_trial = {w_part, w_q[WIDTH-1]};
            w_q     = {w_q[WIDTH-2:0], 1'b0};
            if (w_trial >= {1'b0, r_div}) begin
                w_trial = w_trial - {1'b0, r_div};
                w_q[0]  = 1'b1;
            end
            w_part = w_trial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_part <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q    <= dividend;
                        r_div  <= divisor;
                        r_part <= '0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_q    <= w_q;
                    r_part <= w_part;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot <= w_q;
                        r_rem  <= w_part;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divu_iter.sv
// Scoreboard bench for divu_iter: one instance at 1 step/cycle, one at 4 steps/cycle.
module tb_divu_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] dividend1, divisor1, quotient1, remainder1;
    logic        rst4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] dividend4, divisor4, quotient4, remainder4;

    divu_iter #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .dividend(dividend1), .divisor(divisor1), .out_valid(out_valid1),
        .out_ready(out_ready1), .quotient(quotient1), .remainder(remainder1));

    divu_iter #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .dividend(dividend4), .divisor(divisor4), .out_valid(out_valid4),
        .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];
    int   tests = 0;
    int   fails = 0;
    bit   rnd4  = 1'b0;

    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'd0;
            3:       return 32'd1;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        dividend1 = a; divisor1 = b; in_valid1 = 1'b1;
        @(negedge clk);
        while (!in_ready1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout1", 32'(in_ready1), 32'd1);
        @(posedge clk);
        sb1.push_back(ref_div(a, b));
        #1;
        in_valid1 = 1'b0; dividend1 = $urandom; divisor1 = $urandom;
    endtask

    task automatic send4(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        dividend4 = a; divisor4 = b; in_valid4 = 1'b1;
        @(negedge clk);
        while (!in_ready4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout4", 32'(in_ready4), 32'd1);
        @(posedge clk);
        sb4.push_back(ref_div(a, b));
        #1;
        in_valid4 = 1'b0; dividend4 = $urandom; divisor4 = $urandom;
    endtask

    task automatic drain1();
        int n = 0;
        while (sb1.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout1", 32'(sb1.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain4();
        int n = 0;
        while (sb4.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout4", 32'(sb4.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitors: pop on handshake, check fixed latency, hold under stall, and the ready/valid exclusion.
    int          cyc1 = 0, acc1 = 0, cyc4 = 0, acc4 = 0;
    logic        pv1 = 1'b0, pr1 = 1'b0, pv4 = 1'b0, pr4 = 1'b0;
    logic [31:0] pq1, prm1, pq4, prm4;

    always @(negedge clk) begin : mon1
        exp_t e;
        cyc1++;
        if (!rst1) begin
            chk("excl1", 32'(in_ready1 & out_valid1), 32'd0);
            if (in_valid1 && in_ready1) acc1 = cyc1;
            if (out_valid1 && !pv1) chk("latency1", 32'(cyc1 - acc1 - 1), 32'd32);
            if (pv1 && !pr1) begin
                chk("hold_valid1", 32'(out_valid1), 32'd1);
                chk("hold_quot1", quotient1, pq1);
                chk("hold_rem1", remainder1, prm1);
            end
            if (out_valid1 && out_ready1) begin
                if (sb1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious1: got result %h r %h, expected none", quotient1, remainder1);
                end else begin
                    e = sb1.pop_front();
                    chk("quot1", quotient1, e.q);
                    chk("rem1", remainder1, e.r);
                end
            end
        end
        pv1 = out_valid1; pr1 = out_ready1; pq1 = quotient1; prm1 = remainder1;
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        cyc4++;
        if (!rst4) begin
            chk("excl4", 32'(in_ready4 & out_valid4), 32'd0);
            if (in_valid4 && in_ready4) acc4 = cyc4;
            if (out_valid4 && !pv4) chk("latency4", 32'(cyc4 - acc4 - 1), 32'd8);
            if (pv4 && !pr4) begin
                chk("hold_valid4", 32'(out_valid4), 32'd1);
                chk("hold_quot4", quotient4, pq4);
                chk("hold_rem4", remainder4, prm4);
            end
            if (out_valid4 && out_ready4) begin
                if (sb4.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious4: got result %h r %h, expected none", quotient4, remainder4);
                end else begin
                    e = sb4.pop_front();
                    chk("quot4", quotient4, e.q);
                    chk("rem4", remainder4, e.r);
                end
            end
        end
        pv4 = out_valid4; pr4 = out_ready4; pq4 = quotient4; prm4 = remainder4;
    end

    initial begin : stall4
        forever begin
            @(posedge clk); #1;
            if (rnd4) out_ready4 = ($urandom_range(0, 3) != 0);
        end
    end

    logic [31:0] dir_a [6] = '{32'd100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'h8000_0000};
    logic [31:0] dir_b [6] = '{32'd7,   32'd0,         32'd1,         32'd9, 32'd3, 32'hFFFF_FFFF};

    initial begin : main
        int n;
        rst1 = 1'b1; rst4 = 1'b1;
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        out_ready1 = 1'b1; out_ready4 = 1'b1;
        dividend1 = '0; divisor1 = '0; dividend4 = '0; divisor4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready1), 32'd0);
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_quot", quotient1, 32'd0);
        chk("rst_rem", remainder1, 32'd0);
        @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready1), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send1(dir_a[i], dir_b[i]);
            drain1();
        end

        // Backpressure: result held in DONE while in_valid is pulsed.
        out_ready1 = 1'b0;
        send1(32'd1000, 32'd7);
        n = 0;
        while (!out_valid1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_done", 32'(out_valid1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready1), 32'd0);
            in_valid1 = i[0];
            dividend1 = $urandom; divisor1 = $urandom;
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid1), 32'd0);
        chk("bp_release_ready", 32'(in_ready1), 32'd1);
        chk("bp_nothing_queued", 32'(sb1.size()), 32'd0);

        // Asynchronous reset mid-RUN abandons the op.
        send1(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #3;
        rst1 = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid1), 32'd0);
        chk("arst_in_ready", 32'(in_ready1), 32'd0);
        chk("arst_quot", quotient1, 32'd0);
        chk("arst_rem", remainder1, 32'd0);
        sb1.delete();
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        @(posedge clk); #1;
        send1(32'd20, 32'd4);
        drain1();

        for (int i = 0; i < 50; i++) send1(rnd_op(), rnd_op());
        drain1();

        send4(32'd1000, 32'd3);
        drain4();
        rnd4 = 1'b1;
        for (int i = 0; i < 2000; i++) send4(rnd_op(), rnd_op());
        drain4();
        rnd4 = 1'b0;
        out_ready4 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
